// File: rtl/mem_map_pkg.sv
// Memory map and FSM encodings shared by the bus decoder and its address decode.
// Region table is indexed so that bit 2 = flash, bit 1 = sram, bit 0 = periph.
package mem_map_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int NUM_SLAVES = 3;
    localparam int SEL_FLASH  = 2;
    localparam int SEL_SRAM   = 1;
    localparam int SEL_PERIPH = 0;

    localparam logic [31:0] FLASH_BASE  = 32'h0000_0000;
    localparam logic [31:0] FLASH_MASK  = 32'hFFFE_0000;
    localparam logic [31:0] SRAM_BASE   = 32'h2000_0000;
    localparam logic [31:0] SRAM_MASK   = 32'hFFFF_0000;
    localparam logic [31:0] PERIPH_BASE = 32'h4000_0000;
    localparam logic [31:0] PERIPH_MASK = 32'hFFFF_0000;

    localparam logic [NUM_SLAVES-1:0][31:0] REGION_BASE = {FLASH_BASE, SRAM_BASE, PERIPH_BASE};
    localparam logic [NUM_SLAVES-1:0][31:0] REGION_MASK = {FLASH_MASK, SRAM_MASK, PERIPH_MASK};

    localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

    function automatic logic addr_hit(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] mask);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/mem_bus_decoder_if.sv
// CPU-side, slave-side and error signals of the memory bus decoder.
// master = CPU plus slaves (the environment), slave = the decoder itself.
interface mem_bus_decoder_if;
    logic        mem_valid;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    logic [3:0]  s_wstrb;
    logic [31:0] s_wdata;
    logic [14:0] s_addr;

    logic        flash_select;
    logic        flash_ready;
    logic [31:0] flash_rdata;
    logic        sram_select;
    logic        sram_ready;
    logic [31:0] sram_rdata;
    logic        periph_select;
    logic        periph_ready;
    logic [31:0] periph_rdata;

    logic        bus_err;
    logic [31:0] err_addr;
    logic        err_clr;

    modport master (
        output mem_valid, mem_wstrb, mem_addr, mem_wdata, err_clr,
        output flash_ready, flash_rdata, sram_ready, sram_rdata, periph_ready, periph_rdata,
        input  mem_ready, mem_rdata, s_wstrb, s_wdata, s_addr,
        input  flash_select, sram_select, periph_select, bus_err, err_addr
    );

    modport slave (
        input  mem_valid, mem_wstrb, mem_addr, mem_wdata, err_clr,
        input  flash_ready, flash_rdata, sram_ready, sram_rdata, periph_ready, periph_rdata,
        output mem_ready, mem_rdata, s_wstrb, s_wdata, s_addr,
        output flash_select, sram_select, periph_select, bus_err, err_addr
    );
endinterface

// File: rtl/mem_addr_decode.sv
// Combinational region decode: one-hot {flash, sram, periph} plus an unmapped flag.
module mem_addr_decode
    import mem_map_pkg::*;
(
    input  logic [31:0]           mem_addr,
    output logic [NUM_SLAVES-1:0] sel_onehot,
    output logic                  unmapped
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_region
            assign sel_onehot[gi] = addr_hit(mem_addr, REGION_BASE[gi], REGION_MASK[gi]);
        end
    endgenerate

    assign unmapped = ~|sel_onehot;

endmodule

// File: rtl/mem_bus_decoder.sv
// Memory bus decoder: routes CPU accesses to flash/sram/periph and flags bad accesses.
// Optional slave response timeout is built when MEM_BUS_TIMEOUT_EN is defined.
module mem_bus_decoder
    import mem_map_pkg::*;
#(
    parameter int CLK_FREQ       = 27_000_000,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic             clk,
    input  logic             reset_n,
    mem_bus_decoder_if.slave bus
);

    generate
        if (CLK_FREQ <= 0 || TIMEOUT_CYCLES < 16 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
            $error("mem_bus_decoder: illegal CLK_FREQ or TIMEOUT_CYCLES");
        end
    endgenerate

    state_t                  state_reg, state_next;
    logic [NUM_SLAVES-1:0]   sel_reg, sel_next;
    logic [14:0]             waddr_reg, waddr_next;
    logic [3:0]              wstrb_reg, wstrb_next;
    logic [31:0]             wdata_reg, wdata_next;
    logic [31:0]             rdata_reg, rdata_next;
    logic                    bus_err_reg, bus_err_next;
    logic [31:0]             err_addr_reg, err_addr_next;
    logic                    err_set;
    logic [31:0]             err_addr_src;

    logic [NUM_SLAVES-1:0]   dec_sel;
    logic                    dec_unmapped;
    logic [NUM_SLAVES-1:0]   ready_vec;
    logic [NUM_SLAVES-1:0][31:0] rdata_vec;
    logic                    slave_ready;
    logic [31:0]             slave_rdata;
    logic                    in_access;

    mem_addr_decode u_decode (
        .mem_addr   (bus.mem_addr),
        .sel_onehot (dec_sel),
        .unmapped   (dec_unmapped)
    );

    assign ready_vec = {bus.flash_ready, bus.sram_ready, bus.periph_ready};
    assign rdata_vec = {bus.flash_rdata, bus.sram_rdata, bus.periph_rdata};

    // Only the registered selection qualifies ready, so stray readies from other slaves are ignored.
    assign slave_ready = |(ready_vec & sel_reg);

    always_comb begin
        slave_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_reg[i]) slave_rdata = slave_rdata | rdata_vec[i];
        end
    end

    assign in_access         = (state_reg == ACCESS);
    assign bus.flash_select  = in_access & sel_reg[SEL_FLASH];
    assign bus.sram_select   = in_access & sel_reg[SEL_SRAM];
    assign bus.periph_select = in_access & sel_reg[SEL_PERIPH];
    assign bus.mem_ready     = (state_reg == RESP);
    assign bus.mem_rdata     = rdata_reg;
    assign bus.s_addr        = waddr_reg;
    assign bus.s_wstrb       = wstrb_reg;
    assign bus.s_wdata       = wdata_reg;
    assign bus.bus_err       = bus_err_reg;
    assign bus.err_addr      = err_addr_reg;

`ifdef MEM_BUS_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

    logic [31:0]      addr_reg, addr_next;
    logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_reg    <= '0;
            tmo_cnt_reg <= '0;
        end else begin
            addr_reg    <= addr_next;
            tmo_cnt_reg <= tmo_cnt_next;
        end
    end
`endif

    always_comb begin
        state_next    = state_reg;
        sel_next      = sel_reg;
        waddr_next    = waddr_reg;
        wstrb_next    = wstrb_reg;
        wdata_next    = wdata_reg;
        rdata_next    = rdata_reg;
        err_set       = 1'b0;
        err_addr_src  = bus.mem_addr;
`ifdef MEM_BUS_TIMEOUT_EN
        addr_next     = addr_reg;
        tmo_cnt_next  = tmo_cnt_reg;
`endif

        case (state_reg)
            IDLE: begin
                if (bus.mem_valid) begin
                    sel_next   = dec_sel;
                    waddr_next = bus.mem_addr[16:2];
                    wstrb_next = bus.mem_wstrb;
                    wdata_next = bus.mem_wdata;
`ifdef MEM_BUS_TIMEOUT_EN
                    addr_next    = bus.mem_addr;
                    tmo_cnt_next = '0;
`endif
                    if (dec_unmapped) begin
                        rdata_next = ERR_WORD;
                        err_set    = 1'b1;
                        state_next = RESP;
                    end else begin
                        state_next = ACCESS;
                    end
                end
            end
            ACCESS: begin
                // A ready on the final timeout cycle still counts as a normal completion.
                if (slave_ready) begin
                    rdata_next = (wstrb_reg == 4'b0000) ? slave_rdata : 32'h0;
                    state_next = RESP;
`ifdef MEM_BUS_TIMEOUT_EN
                end else if (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    rdata_next   = ERR_WORD;
                    err_set      = 1'b1;
                    err_addr_src = addr_reg;
                    state_next   = RESP;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 1'b1;
`endif
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A new error beats a simultaneous clear; the first error address is held while flagged.
        bus_err_next  = bus_err_reg;
        err_addr_next = err_addr_reg;
        if (err_set) begin
            bus_err_next = 1'b1;
            if (!bus_err_reg || bus.err_clr) err_addr_next = err_addr_src;
        end else if (bus.err_clr) begin
            bus_err_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            sel_reg      <= '0;
            waddr_reg    <= '0;
            wstrb_reg    <= '0;
            wdata_reg    <= '0;
            rdata_reg    <= '0;
            bus_err_reg  <= 1'b0;
            err_addr_reg <= '0;
        end else begin
            state_reg    <= state_next;
            sel_reg      <= sel_next;
            waddr_reg    <= waddr_next;
            wstrb_reg    <= wstrb_next;
            wdata_reg    <= wdata_next;
            rdata_reg    <= rdata_next;
            bus_err_reg  <= bus_err_next;
            err_addr_reg <= err_addr_next;
        end
    end

endmodule

// File: tb/tb_mem_bus_decoder.sv
// Scoreboard bench for mem_bus_decoder; define MEM_BUS_TIMEOUT_EN to add the timeout cases.
// Latency = clock edges from the edge sampling mem_valid to the edge sampling mem_ready, inclusive.
module tb_mem_bus_decoder;

`ifdef MEM_BUS_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1023;
`endif

    localparam logic [31:0] FLASH_DATA  = 32'h1234_5678;
    localparam logic [31:0] SRAM_DATA   = 32'h5A5A_0F0F;
    localparam logic [31:0] PERIPH_DATA = 32'h0BAD_CAFE;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   rdy_delay = 0;

    mem_bus_decoder_if bus ();

    mem_bus_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
        logic        chk_ea;
        logic [31:0] ea;
        logic [2:0]  sel;
        int          sel_cycles;
        logic [14:0] saddr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        int          issue;
        int          lat;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Slave model: unselected slaves hold ready high; the selected one answers after rdy_delay select cycles.
    initial begin
        int sel_cnt;
        sel_cnt = 0;
        bus.flash_rdata  = FLASH_DATA;
        bus.sram_rdata   = SRAM_DATA;
        bus.periph_rdata = PERIPH_DATA;
        bus.flash_ready  = 1'b1;
        bus.sram_ready   = 1'b1;
        bus.periph_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.flash_select || bus.sram_select || bus.periph_select) sel_cnt++;
            else sel_cnt = 0;
            bus.flash_ready  = bus.flash_select  ? (rdy_delay != 0 && sel_cnt == rdy_delay) : 1'b1;
            bus.sram_ready   = bus.sram_select   ? (rdy_delay != 0 && sel_cnt == rdy_delay) : 1'b1;
            bus.periph_ready = bus.periph_select ? (rdy_delay != 0 && sel_cnt == rdy_delay) : 1'b1;
        end
    end

    // Monitor: tracks select activity and checks each mem_ready pulse against the scoreboard.
    initial begin
        logic [2:0]  seen_sel, sel_now;
        logic        multi, unstable;
        int          sel_cyc;
        logic [14:0] cap_addr;
        logic [3:0]  cap_wstrb;
        logic [31:0] cap_wdata;
        exp_t        e;
        seen_sel = '0; multi = 1'b0; unstable = 1'b0; sel_cyc = 0;
        cap_addr = '0; cap_wstrb = '0; cap_wdata = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                seen_sel = '0; multi = 1'b0; unstable = 1'b0; sel_cyc = 0;
                continue;
            end
            sel_now = {bus.flash_select, bus.sram_select, bus.periph_select};
            if (sel_now != 3'b000) begin
                if ($countones(sel_now) != 1) multi = 1'b1;
                if (sel_cyc == 0) begin
                    cap_addr = bus.s_addr; cap_wstrb = bus.s_wstrb; cap_wdata = bus.s_wdata;
                end else if (bus.s_addr !== cap_addr || bus.s_wstrb !== cap_wstrb
                             || bus.s_wdata !== cap_wdata) begin
                    unstable = 1'b1;
                end
                seen_sel = seen_sel | sel_now;
                sel_cyc++;
            end
            if (bus.mem_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_ready actual=1 required=0 at cycle %0d", cyc);
                end else begin
                    e = exp_q.pop_front();
                    $display("txn %s rdata=%h bus_err=%0d err_addr=%h sel=%b sel_cycles=%0d latency=%0d",
                             e.name, bus.mem_rdata, bus.bus_err, bus.err_addr, seen_sel, sel_cyc,
                             cyc - e.issue + 1);
                    chk({e.name, "_rdata"}, bus.mem_rdata, e.rdata);
                    chk({e.name, "_bus_err"}, 32'(bus.bus_err), 32'(e.err));
                    if (e.chk_ea) chk({e.name, "_err_addr"}, bus.err_addr, e.ea);
                    chk({e.name, "_select"}, 32'(seen_sel), 32'(e.sel));
                    chk({e.name, "_sel_cycles"}, 32'(sel_cyc), 32'(e.sel_cycles));
                    chk({e.name, "_latency"}, 32'(cyc - e.issue + 1), 32'(e.lat));
                    chk({e.name, "_onehot"}, 32'(multi), 32'd0);
                    if (e.sel != 3'b000) begin
                        chk({e.name, "_s_addr"}, 32'(cap_addr), 32'(e.saddr));
                        chk({e.name, "_s_wstrb"}, 32'(cap_wstrb), 32'(e.wstrb));
                        chk({e.name, "_s_wdata"}, cap_wdata, e.wdata);
                        chk({e.name, "_stable"}, 32'(unstable), 32'd0);
                    end
                end
                seen_sel = '0; multi = 1'b0; unstable = 1'b0; sel_cyc = 0;
            end
        end
    end

    task automatic access(input string name, input logic [31:0] addr, input logic [3:0] wstrb,
                          input logic [31:0] wdata, input int delay, input bit clr,
                          input logic [31:0] x_rdata, input bit x_err, input bit x_chk_ea,
                          input logic [31:0] x_ea, input logic [2:0] x_sel, input int x_selcyc,
                          input logic [14:0] x_saddr, input int x_lat);
        exp_t e;
        int   n;
        @(negedge clk);
        e.name = name; e.rdata = x_rdata; e.err = x_err; e.chk_ea = x_chk_ea; e.ea = x_ea;
        e.sel = x_sel; e.sel_cycles = x_selcyc; e.saddr = x_saddr; e.wstrb = wstrb;
        e.wdata = wdata; e.issue = cyc; e.lat = x_lat;
        exp_q.push_back(e);
        rdy_delay     = delay;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = addr;
        bus.mem_wstrb = wstrb;
        bus.mem_wdata = wdata;
        bus.err_clr   = clr;
        @(negedge clk);
        // Drop the request after one cycle and scramble the bus: the decoder must have registered it.
        bus.mem_valid = 1'b0;
        bus.err_clr   = 1'b0;
        bus.mem_addr  = 32'hFFFF_FFFF;
        bus.mem_wstrb = 4'b0000;
        bus.mem_wdata = 32'hFFFF_FFFF;
        n = 0;
        while (!bus.mem_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.mem_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_ready_wait actual=no_ready required=ready_within_200", name);
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.mem_valid = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wstrb = '0;
        bus.mem_wdata = '0;
        bus.err_clr   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mem_ready", 32'(bus.mem_ready), 32'd0);
        chk("rst_selects", 32'({bus.flash_select, bus.sram_select, bus.periph_select}), 32'd0);
        chk("rst_mem_rdata", bus.mem_rdata, 32'h0);
        chk("rst_s_addr", 32'(bus.s_addr), 32'h0);
        chk("rst_s_wstrb", 32'(bus.s_wstrb), 32'h0);
        chk("rst_s_wdata", bus.s_wdata, 32'h0);
        chk("rst_bus_err", 32'(bus.bus_err), 32'h0);
        chk("rst_err_addr", bus.err_addr, 32'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        //      name           addr          wstrb    wdata          dly clr rdata        err chkea ea            sel     cyc saddr    lat
        access("flash_rd",     32'h0000_0104, 4'b0000, 32'h0000_0000, 5, 0, FLASH_DATA,   0, 1, 32'h0,         3'b100, 5, 15'h041,  7);
        access("sram_wr",      32'h2000_0010, 4'b0011, 32'hCAFE_1234, 2, 0, 32'h0,        0, 1, 32'h0,         3'b010, 2, 15'h004,  4);
        access("periph_rd",    32'h4000_0FFC, 4'b0000, 32'h0000_0000, 1, 0, PERIPH_DATA,  0, 1, 32'h0,         3'b001, 1, 15'h3FF,  3);
        access("flash_top",    32'h0001_FFFC, 4'b0000, 32'h0000_0000, 1, 0, FLASH_DATA,   0, 1, 32'h0,         3'b100, 1, 15'h7FFF, 3);
        access("unmap_rd",     32'h8000_0000, 4'b0000, 32'h0000_0000, 1, 0, 32'hDEAD_BEEF,1, 1, 32'h8000_0000, 3'b000, 0, 15'h0,    2);
        access("unmap_wr",     32'h0002_0000, 4'b1111, 32'h1111_2222, 1, 0, 32'hDEAD_BEEF,1, 1, 32'h8000_0000, 3'b000, 0, 15'h0,    2);
        access("sram_rd",      32'h2000_FFFC, 4'b0000, 32'h0000_0000, 3, 0, SRAM_DATA,    1, 1, 32'h8000_0000, 3'b010, 3, 15'h3FFF, 5);
        access("clr_unmap",    32'h6000_0000, 4'b0000, 32'h0000_0000, 1, 1, 32'hDEAD_BEEF,1, 1, 32'h6000_0000, 3'b000, 0, 15'h0,    2);
        access("periph_wr",    32'h4000_0008, 4'b1000, 32'h8765_4321, 3, 0, 32'h0,        1, 1, 32'h6000_0000, 3'b001, 3, 15'h002,  5);

        @(negedge clk);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        chk("err_clr_bus_err", 32'(bus.bus_err), 32'd0);

        access("flash_rd2",    32'h0000_0008, 4'b0000, 32'h0000_0000, 1, 0, FLASH_DATA,   0, 0, 32'h0,         3'b100, 1, 15'h002,  3);
`ifdef MEM_BUS_TIMEOUT_EN
        access("periph_tmo",   32'h4000_0020, 4'b0000, 32'h0000_0000, 0, 0, 32'hDEAD_BEEF,1, 1, 32'h4000_0020, 3'b001, 16, 15'h008, 18);
        access("rdy_at_tmo",   32'h4000_0024, 4'b0000, 32'h0000_0000, 16,0, PERIPH_DATA,  1, 1, 32'h4000_0020, 3'b001, 16, 15'h009, 18);
`endif

        // Reset in the middle of a flash access that never completes.
        @(negedge clk);
        rdy_delay     = 0;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h0000_0104;
        bus.mem_wstrb = 4'b0000;
        @(negedge clk);
        bus.mem_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_select_before", 32'(bus.flash_select), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("abort_select_drop", 32'(bus.flash_select), 32'd0);
        chk("abort_mem_ready", 32'(bus.mem_ready), 32'd0);
        chk("abort_mem_rdata", bus.mem_rdata, 32'h0);
        chk("abort_bus_err", 32'(bus.bus_err), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        $display("txn reset_abort no mem_ready expected");

        access("flash_after",  32'h0000_0104, 4'b0000, 32'h0000_0000, 2, 0, FLASH_DATA,   0, 1, 32'h0,         3'b100, 2, 15'h041,  4);

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain actual=%0d_pending required=0_pending", exp_q.size());
        end
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_bus_decoder.md
MEM_BUS_DECODER -- requirements
Module: mem_bus_decoder

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 27_000_000, system clock frequency in Hz (informational, used for timeout sizing).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1023, slave response limit in clocks; legal range 16..65535.
REQ-003 SHALL have ports, in order: clk in 1 system clock; reset_n in 1 reset. The block uses one clock, and reset is asynchronous and active-low.
REQ-004 SHALL have CPU-side ports: mem_valid in 1; mem_wstrb in 4; mem_addr in 32 byte address; mem_wdata in 32; mem_ready out 1; mem_rdata out 32.
REQ-005 SHALL have slave-shared ports: s_wstrb out 4; s_wdata out 32; s_addr out 15 word address (mem_addr[16:2]).
REQ-006 SHALL have per-slave ports (X = flash, sram, periph): X_select out 1; X_ready in 1; X_rdata in 32.
REQ-007 SHALL have error ports: bus_err out 1 sticky error flag; err_addr out 32 address of the first faulting access; err_clr in 1 clears the error flag.

Function
REQ-008 SHALL decode addresses as follows: flash when mem_addr[31:17]==0; sram when mem_addr[31:16]==16'h2000; periph when mem_addr[31:16]==16'h4000; any other address is unmapped.
REQ-009 SHALL use the FSM states IDLE, ACCESS, RESP, with encodings 0, 1, 2.
REQ-010 SHALL, in IDLE with mem_valid=1, register the decode result, mem_wstrb, mem_wdata and the word address, then go to ACCESS; if the address is unmapped it SHALL go to RESP instead.
REQ-011 SHALL, in ACCESS, hold exactly one X_select high, with s_addr, s_wstrb and s_wdata held stable.
REQ-012 SHALL, on the clock edge at which the selected X_ready is sampled 1, drop X_select, capture X_rdata into mem_rdata, and go to RESP.
REQ-013 SHALL ignore X_ready from unselected slaves.
REQ-014 SHALL, in RESP, drive mem_ready=1 for exactly one cycle and then return to IDLE.
REQ-015 SHALL NOT sample mem_valid in RESP, so a new request is accepted no earlier than the IDLE cycle that follows.
REQ-016 SHALL have a minimum latency, from mem_valid sampled to mem_ready high, of 3 clocks when the slave ready is asserted 1 cycle after select.
REQ-017 SHALL, on an unmapped access, return mem_rdata=32'hDEAD_BEEF, set bus_err if it is clear, and load err_addr with mem_addr; writes to unmapped addresses are discarded.
REQ-018 SHALL treat a read response as mem_rdata = captured data, and a write response as mem_rdata = 0.
REQ-019 SHALL, when err_clr and a new error occur in the same cycle, let the new error win: bus_err=1 and err_addr is updated.
REQ-020 SHALL hold err_addr while bus_err=1; later errors do not overwrite it.
REQ-021 SHALL drop mem_valid silently if it deasserts in ACCESS (a protocol violation): the access completes and mem_ready still pulses once.

Reset
REQ-022 SHALL, on reset_n=0, asynchronously set state=IDLE; all X_select=0; mem_ready=0; mem_rdata=0; s_addr=0; s_wstrb=0; s_wdata=0; bus_err=0; err_addr=0; timeout counter=0.
REQ-023 SHALL, on reset mid-ACCESS, drop select immediately and never pulse mem_ready for the aborted access.

Configuration
REQ-024 SHALL, with the macro MEM_BUS_TIMEOUT_EN defined, count ACCESS cycles; when the count reaches TIMEOUT_CYCLES, the block drops select, returns 32'hDEAD_BEEF, sets bus_err and err_addr per REQ-017/019/020, and goes to RESP.
REQ-025 SHALL reset the timeout counter on each entry to ACCESS.
REQ-026 SHALL, when X_ready arrives on the same cycle as the timeout, treat the access as normal completion (ready wins).
REQ-027 SHALL, without MEM_BUS_TIMEOUT_EN, have no counter logic and let ACCESS wait indefinitely; bus_err is then set only by unmapped accesses.

Structure
REQ-028 SHALL place the region base/mask constants, the 32'hDEAD_BEEF error word and the FSM state encodings in the shared package mem_map_pkg.
REQ-029 SHALL implement decode as the combinational sub-module mem_addr_decode (input mem_addr; output one-hot {flash, sram, periph} and unmapped).

Verification
REQ-030 SHALL cover a flash read: addr 32'h0000_0104, flash_ready asserted 5 cycles after select -> flash_select high for 5 cycles, s_addr=15'h041, mem_ready 1 cycle later with the flash data.
REQ-031 SHALL cover an sram write: addr 32'h2000_0010, wstrb 4'b0011, wdata 32'hCAFE_1234 -> sram_select only, s_wstrb=4'b0011, mem_rdata=0.
REQ-032 SHALL cover an unmapped read: addr 32'h8000_0000 -> no select, mem_ready after 2 clocks, mem_rdata=32'hDEAD_BEEF, bus_err=1, err_addr=32'h8000_0000.
REQ-033 SHALL cover a timeout with the macro defined and TIMEOUT_CYCLES=16: periph never ready -> select drops after 16 cycles, bus_err=1, mem_rdata=32'hDEAD_BEEF.
REQ-034 SHALL cover err_clr together with an unmapped access at 32'h6000_0000 -> bus_err stays 1, err_addr=32'h6000_0000.
REQ-035 SHALL cover reset_n pulsed low during a flash ACCESS -> flash_select=0 immediately, no mem_ready pulse, next read completes normally.
